// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA raster timing from a 50 MHz clock using an internal /2 pixel phase.
// Counters and derived sync/blank outputs are registered together, so they never skew.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] Hcnt,
   output logic [9:0] Vcnt,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       vga_clk,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT10 = 10'(V_ACTIVE);
   localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
         $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
      end
   endgenerate

   logic       ph_q, ph_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       tick_q, tick_d;
   logic [9:0] hcnt_nx, vcnt_nx;
   logic [10:0] hcnt_ext, vcnt_ext;

   always_comb begin
      hcnt_nx = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
      vcnt_nx = vcnt_q;
      if (hcnt_q == H_LAST) begin
         vcnt_nx = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end
      hcnt_ext = {1'b0, hcnt_nx};
      vcnt_ext = {1'b0, vcnt_nx};

      ph_d    = ~ph_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      blank_d = blank_q;
      tick_d  = 1'b0;

      // Derived outputs are decoded from the next counter values so they land on the same edge.
      if (ph_q) begin
         hcnt_d  = hcnt_nx;
         vcnt_d  = vcnt_nx;
         hs_d    = (hcnt_ext >= HS_BEG && hcnt_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
         vs_d    = (vcnt_ext >= VS_BEG && vcnt_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
         blank_d = (hcnt_ext < H_ACT11) && (vcnt_ext < V_ACT11);
         tick_d  = (hcnt_nx == 10'd0) && (vcnt_nx == V_ACT10);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ph_q    <= 1'b0;
         hcnt_q  <= H_LAST;
         vcnt_q  <= V_LAST;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         blank_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         ph_q    <= ph_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
      end
   end

   assign Hcnt       = hcnt_q;
   assign Vcnt       = vcnt_q;
   assign hs         = hs_q;
   assign vs         = vs_q;
   assign blank      = blank_q;
   assign vga_clk    = ph_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a small, positive-sync instance
// checked every clock against an arithmetic raster model, with random async resets.
module tb_vga_sync_gen;

   localparam int SHA = 20, SHF = 4, SHS = 6, SHB = 5;
   localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
   localparam int S_NT = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

   logic       clk;
   logic       reset;
   logic [9:0] d_h, d_v, s_h, s_v;
   logic       d_hs, d_vs, d_blank, d_vclk, d_tick;
   logic       s_hs, s_vs, s_blank, s_vclk, s_tick;

   int     n_checks;
   int     n_err;
   longint n;
   longint last_tick;
   longint last_fall;
   longint fall_n;
   int     blank_cnt;
   logic   prev_hs;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       vclk;
      logic       tick;
   } exp_t;

   vga_sync_gen dut_d (
      .clk(clk), .reset(reset), .Hcnt(d_h), .Vcnt(d_v), .hs(d_hs), .vs(d_vs),
      .blank(d_blank), .vga_clk(d_vclk), .frame_tick(d_tick)
   );

   vga_sync_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .reset(reset), .Hcnt(s_h), .Vcnt(s_v), .hs(s_hs), .vs(s_vs),
      .blank(s_blank), .vga_clk(s_vclk), .frame_tick(s_tick)
   );

   always #5 clk = ~clk;

   // Raster position from the number of clk edges since reset release: every second
   // edge advances one pixel, starting one pixel before the origin.
   function automatic exp_t model(input longint ne, input int ha, input int hf, input int hsy,
                                  input int hb, input int va, input int vf, input int vsy,
                                  input int vb, input bit pol);
      exp_t   e;
      longint ht, vt, nt, t;
      int     h, v;
      ht = longint'(ha + hf + hsy + hb);
      vt = longint'(va + vf + vsy + vb);
      nt = ht * vt;
      t  = (ne / 2 + nt - 1) % nt;
      h  = int'(t % ht);
      v  = int'(t / ht);
      e.h     = 10'(h);
      e.v     = 10'(v);
      e.hs    = (h >= ha + hf && h < ha + hf + hsy) ? pol : !pol;
      e.vs    = (v >= va + vf && v < va + vf + vsy) ? pol : !pol;
      e.blank = (h < ha) && (v < va);
      e.vclk  = (ne % 2) == 1;
      e.tick  = (ne > 0) && (ne % 2 == 0) && (h == 0) && (v == va);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic check_dut(input string p, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                            input logic hs_o, input logic vs_o, input logic bl, input logic vc,
                            input logic tk);
      chk({p, ".Hcnt"}, 32'(h), 32'(e.h));
      chk({p, ".Vcnt"}, 32'(v), 32'(e.v));
      chk({p, ".hs"}, 32'(hs_o), 32'(e.hs));
      chk({p, ".vs"}, 32'(vs_o), 32'(e.vs));
      chk({p, ".blank"}, 32'(bl), 32'(e.blank));
      chk({p, ".vga_clk"}, 32'(vc), 32'(e.vclk));
      chk({p, ".frame_tick"}, 32'(tk), 32'(e.tick));
   endtask

   task automatic check_all();
      check_dut("d", model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
                d_h, d_v, d_hs, d_vs, d_blank, d_vclk, d_tick);
      check_dut("s", model(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1),
                s_h, s_v, s_hs, s_vs, s_blank, s_vclk, s_tick);
   endtask

   task automatic clear_aggr();
      last_tick = -1;
      last_fall = -1;
      fall_n    = -1;
      blank_cnt = 0;
      prev_hs   = 1'b1;
   endtask

   // Whole-period properties measured independently of the per-cycle model.
   task automatic sample();
      check_all();
      if (n % 2 == 0 && s_blank === 1'b1) blank_cnt++;
      if (s_tick === 1'b1) begin
         if (last_tick >= 0) begin
            chk("s.tick_period", 32'(n - last_tick), 32'(2 * S_NT));
            chk("s.blank_per_frame", 32'(blank_cnt), 32'(SHA * SVA));
         end
         last_tick = n;
         blank_cnt = 0;
      end
      if (prev_hs === 1'b1 && d_hs === 1'b0) begin
         chk("d.hs_fall_hcnt", 32'(d_h), 32'd656);
         if (last_fall >= 0) chk("d.hs_period", 32'(n - last_fall), 32'd1600);
         last_fall = n;
         fall_n    = n;
      end
      if (prev_hs === 1'b0 && d_hs === 1'b1 && fall_n >= 0) begin
         chk("d.hs_low_len", 32'(n - fall_n), 32'd192);
      end
      prev_hs = d_hs;
   endtask

   task automatic run(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         sample();
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      n = 0;
      check_all();
      clear_aggr();
      reset = 1'b1;
   endtask

   initial begin
      clk      = 1'b0;
      reset    = 1'b0;
      n_checks = 0;
      n_err    = 0;
      n        = 0;
      clear_aggr();
      repeat (3) @(negedge clk);
      release_reset();
      run(6410);

      for (int i = 0; i < 4; i++) begin
         run($urandom_range(50, 2000));
         @(posedge clk);
         #($urandom_range(1, 4));
         reset = 1'b0;
         #1;
         n = 0;
         check_all();
         repeat ($urandom_range(1, 3)) @(negedge clk);
         release_reset();
         run(3000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock, using an internal divide-by-2 pixel phase.
- Directly upstream of the game display/colour stage, which consumes Hcnt/Vcnt to paint pixels and passes HS/VS/VGA_BLANK_N/VGA_CLK to the DAC.
- Also supplies a once-per-frame tick so game logic can step on vertical blank instead of a free-running slow clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hs/vs (0 = active-low)

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-low reset
- Hcnt  out  10  horizontal pixel position; 0..H_ACTIVE-1 visible
- Vcnt  out  10  vertical line position; 0..V_ACTIVE-1 visible
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- blank  out  1  1 = visible pixel (drives VGA_BLANK_N)
- vga_clk  out  1  25 MHz pixel clock to DAC
- frame_tick  out  1  single-clk pulse at start of vertical blank

Behaviour:
- One clock; reset is asynchronous and active-low. Everything is clocked on posedge clk. Reset acts immediately, including mid-line or mid-frame.
- Reset values:
  - internal phase ph=0
  - Hcnt=H_TOTAL-1, Vcnt=V_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800 and V_TOTAL=525
  - hs=vs=~SYNC_POL (inactive, 1 by default)
  - blank=0, vga_clk=0, frame_tick=0
- Phase:
  - ph toggles on every clk edge.
  - An "update edge" is a clk edge at which ph==1 before the edge.
  - The first update edge after reset release is the 2nd rising clk edge.
- Counters change only on update edges:
  - Hcnt increments; at H_TOTAL-1 it wraps to 0.
  - Vcnt increments only on an Hcnt wrap; at V_TOTAL-1 it wraps to 0.
  - The first update edge after reset therefore yields Hcnt=0, Vcnt=0, so frame 0 is complete.
- Derived outputs are registered and change on the same edge as the counters, consistent with the new counter values (zero skew):
  - hs = SYNC_POL when H_ACTIVE+H_FP <= Hcnt < H_ACTIVE+H_FP+H_SYNC (656..751 by default), else ~SYNC_POL.
  - vs = SYNC_POL when V_ACTIVE+V_FP <= Vcnt < V_ACTIVE+V_FP+V_SYNC (490..491 by default), else ~SYNC_POL. vs changes only together with an Hcnt wrap to 0.
  - blank = 1 iff Hcnt < H_ACTIVE and Vcnt < V_ACTIVE.
- vga_clk = ph:
  - low for the clk cycle after an update edge, high for the next.
  - Its rising edge therefore falls mid-pixel, with data stable for one full clk period either side.
- frame_tick: 1 for exactly one clk cycle, in the cycle following the update edge that produces Hcnt=0, Vcnt=V_ACTIVE. It is 0 at all other times.
- Widths and parameter rules:
  - Counters are fixed at 10 bits.
  - Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; no other checks.
  - Counter outputs never exceed TOTAL-1.
- Periods with default parameters:
  - line = 1600 clk
  - frame = 525 lines = 840000 clk
  - hs low = 192 clk
  - vs low = 3200 clk
- No enable or stall input: timing is free-running after reset release.

Test Plan:
1. Release reset, sample each clk → at 1st rising edge nothing but vga_clk=1; at 2nd rising edge Hcnt=0, Vcnt=0, blank=1, hs=vs=1, vga_clk=0.
2. Run 3 lines → hs falls at the edge giving Hcnt=656 and stays low 192 clk; consecutive hs falling edges are 1600 clk apart; Hcnt wraps 799→0 with Vcnt+1.
3. Run 2 full frames → vs low only while Vcnt in 490..491, 3200 clk each time; vs falling edges are 840000 clk apart; Vcnt wraps 524→0.
4. Count blank=1 update edges per frame → 307200 total, 640 per visible line; blank=0 at (Hcnt=640, Vcnt=0) and at (Hcnt=0, Vcnt=480).
5. Monitor frame_tick over 3 frames → exactly one 1-clk pulse per frame, 840000 clk apart, each in the cycle after Hcnt=0, Vcnt=480 appears.
6. Assert reset asynchronously at Hcnt=300, Vcnt=100, between edges → outputs take reset values immediately without waiting for a clk edge; after release the sequence of test 1 repeats exactly.
